// File: rtl/cache_slot_controller_pkg.sv
// Shared types and default sizing for the cache slot controller slice.
package cache_mem_pkg;

   localparam int unsigned DEF_NUM_SLOTS   = 8;
   localparam int unsigned DEF_KEY_WIDTH   = 16;
   localparam int unsigned DEF_VALUE_WIDTH = 32;

   typedef enum logic [1:0] {
      GET  = 2'd0,
      PUT  = 2'd1,
      DEL  = 2'd2,
      RSVD = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      OK    = 2'd0,
      MISS  = 2'd1,
      FULL  = 2'd2,
      BADOP = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/cache_slot_controller_if.sv
// Request/response handshake bundle between the command decoder and the controller.
interface cache_slot_controller_if
   import cache_mem_pkg::*;
#(
   parameter int unsigned KEY_WIDTH   = DEF_KEY_WIDTH,
   parameter int unsigned VALUE_WIDTH = DEF_VALUE_WIDTH
);
   logic                   req_valid;
   logic                   req_ready;
   logic [1:0]             req_op;
   logic [KEY_WIDTH-1:0]   req_key;
   logic [VALUE_WIDTH-1:0] req_value;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [1:0]             resp_status;
   logic [VALUE_WIDTH-1:0] resp_value;

   modport master (
      output req_valid, req_op, req_key, req_value, resp_ready,
      input  req_ready, resp_valid, resp_status, resp_value
   );

   modport slave (
      input  req_valid, req_op, req_key, req_value, resp_ready,
      output req_ready, resp_valid, resp_status, resp_value
   );
endinterface

// File: rtl/cache_slot_controller_lookup.sv
// Parallel key match and free-slot search across the slot bank; lowest index wins.
module slot_lookup
   import cache_mem_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int unsigned KEY_WIDTH = DEF_KEY_WIDTH,
   localparam int unsigned IDX_W    = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0]           valid_i,
   input  logic [NUM_SLOTS*KEY_WIDTH-1:0] keys_i,
   input  logic [KEY_WIDTH-1:0]           key_i,
   output logic                           hit_o,
   output logic [IDX_W-1:0]               hit_idx_o,
   output logic                           free_avail_o,
   output logic [IDX_W-1:0]               free_idx_o
);
   logic [NUM_SLOTS-1:0] hit_vec;

   // Compare the search key against every valid slot at once
   always_comb begin
      hit_vec = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         hit_vec[i] = valid_i[i] && (keys_i[i*KEY_WIDTH +: KEY_WIDTH] == key_i);
      end
   end

   // Priority encoders scan downward so the lowest matching index is left standing
   always_comb begin
      hit_idx_o  = '0;
      free_idx_o = '0;
      for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
         if (hit_vec[i-1])  hit_idx_o  = IDX_W'(i-1);
         if (!valid_i[i-1]) free_idx_o = IDX_W'(i-1);
      end
   end

   assign hit_o        = |hit_vec;
   assign free_avail_o = ~&valid_i;
endmodule

// File: rtl/cache_slot_controller.sv
// Sequences GET/PUT/DEL requests onto the key/value slot bank, one request at a time.
module cache_slot_controller
   import cache_mem_pkg::*;
#(
   parameter int unsigned NUM_SLOTS   = DEF_NUM_SLOTS,
   parameter int unsigned KEY_WIDTH   = DEF_KEY_WIDTH,
   parameter int unsigned VALUE_WIDTH = DEF_VALUE_WIDTH,
   localparam int unsigned IDX_W      = $clog2(NUM_SLOTS),
   localparam int unsigned OCC_W      = $clog2(NUM_SLOTS+1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   cache_slot_controller_if.slave           bus,
   output logic [OCC_W-1:0]                 occupancy,
   output logic [NUM_SLOTS-1:0]             slot_key_we,
   output logic [NUM_SLOTS-1:0]             slot_val_we,
   output logic [KEY_WIDTH-1:0]             slot_wkey,
   output logic [VALUE_WIDTH-1:0]           slot_wval,
   input  logic [NUM_SLOTS*KEY_WIDTH-1:0]   slot_rkey,
   input  logic [NUM_SLOTS*VALUE_WIDTH-1:0] slot_rval
);
   state_e                 state_q, state_d;
   op_e                    op_q, op_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic [VALUE_WIDTH-1:0] val_q, val_d;
   logic [NUM_SLOTS-1:0]   valid_q, valid_d;
   logic [OCC_W-1:0]       occ_q, occ_d;
   logic [NUM_SLOTS-1:0]   kmask_q, kmask_d;
   logic [NUM_SLOTS-1:0]   vmask_q, vmask_d;
   status_e                status_q, status_d;
   logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;

   logic                   hit, free_avail;
   logic [IDX_W-1:0]       hit_idx, free_idx;
   logic [VALUE_WIDTH-1:0] hit_val;

   slot_lookup #(
      .NUM_SLOTS (NUM_SLOTS),
      .KEY_WIDTH (KEY_WIDTH)
   ) u_lookup (
      .valid_i      (valid_q),
      .keys_i       (slot_rkey),
      .key_i        (key_q),
      .hit_o        (hit),
      .hit_idx_o    (hit_idx),
      .free_avail_o (free_avail),
      .free_idx_o   (free_idx)
   );

   assign hit_val = slot_rval[hit_idx*VALUE_WIDTH +: VALUE_WIDTH];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Request latch, valid bits, occupancy, write targets and pending response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= GET;
         key_q    <= '0;
         val_q    <= '0;
         valid_q  <= '0;
         occ_q    <= '0;
         kmask_q  <= '0;
         vmask_q  <= '0;
         status_q <= OK;
         rvalue_q <= '0;
      end else begin
         op_q     <= op_d;
         key_q    <= key_d;
         val_q    <= val_d;
         valid_q  <= valid_d;
         occ_q    <= occ_d;
         kmask_q  <= kmask_d;
         vmask_q  <= vmask_d;
         status_q <= status_d;
         rvalue_q <= rvalue_d;
      end
   end

   // Next-state and datapath decisions; all slot bookkeeping resolves on leaving LOOKUP
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      key_d    = key_q;
      val_d    = val_q;
      valid_d  = valid_q;
      occ_d    = occ_q;
      kmask_d  = kmask_q;
      vmask_d  = vmask_q;
      status_d = status_q;
      rvalue_d = rvalue_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               op_d    = op_e'(bus.req_op);
               key_d   = bus.req_key;
               val_d   = bus.req_value;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            kmask_d  = '0;
            vmask_d  = '0;
            rvalue_d = '0;
            state_d  = RESP;
            unique case (op_q)
               GET: begin
                  if (hit) begin
                     status_d = OK;
                     rvalue_d = hit_val;
                  end else begin
                     status_d = MISS;
                  end
               end
               PUT: begin
                  if (hit) begin
                     vmask_d[hit_idx] = 1'b1;
                     state_d          = WRITE;
                  end else if (free_avail) begin
                     kmask_d[free_idx] = 1'b1;
                     vmask_d[free_idx] = 1'b1;
                     valid_d[free_idx] = 1'b1;
                     occ_d             = occ_q + OCC_W'(1);
                     state_d           = WRITE;
                  end else begin
                     status_d = FULL;
                  end
               end
               DEL: begin
                  if (hit) begin
                     valid_d[hit_idx] = 1'b0;
                     occ_d            = occ_q - OCC_W'(1);
                     state_d          = WRITE;
                  end else begin
                     status_d = MISS;
                  end
               end
               default: status_d = BADOP;
            endcase
         end
         WRITE: begin
            status_d = OK;
            rvalue_d = '0;
            state_d  = RESP;
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state so reset drops strobes and the response immediately
   always_comb begin
      bus.req_ready   = (state_q == IDLE);
      bus.resp_valid  = (state_q == RESP);
      bus.resp_status = (state_q == RESP) ? status_q : OK;
      bus.resp_value  = (state_q == RESP) ? rvalue_q : '0;
      slot_key_we     = (state_q == WRITE) ? kmask_q : '0;
      slot_val_we     = (state_q == WRITE) ? vmask_q : '0;
      slot_wkey       = key_q;
      slot_wval       = val_q;
      occupancy       = occ_q;
   end
endmodule
